// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the writeback stage.
//   wb_sel_e : writeback result source select
//   F3_*     : load funct3 encodings (width and sign of a load)
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension (purely combinational).
//   word_i   : 32-bit word read from data memory
//   addr_i   : low two bits of the load address (lane select)
//   funct3_i : load funct3 (width and signedness)
//   data_o   : aligned, sign- or zero-extended load value
// Unsupported funct3 encodings pass the raw word through.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    unique case (addr_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    // Halfword loads ignore addr[0].
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {24'd0, byte_sel};
      F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {16'd0, half_sel};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: MEM/WB pipeline register, load alignment, result select,
// register-file write port, forwarding status, retire pulse and optional instret.
//   clk, reset        : clock, synchronous active-high reset
//   stall_i, flush_i  : hold the WB register / load a bubble (stall wins)
//   mem_*_i           : instruction fields from the MEM stage
//   dmem_rdata_i      : synchronous data-memory read word (valid in first WB cycle)
//   rf_rd_o/rf_data_o/rf_we_o : register file write port
//   fwd_valid_o       : WB result is destined for a nonzero rd (not stall-gated)
//   retire_o          : one pulse per completed instruction
//   instret_o         : retired count when WB_INSTRET_EN is defined, else 0
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            mem_valid_i,
  input  logic [4:0]      mem_rd_i,
  input  logic            mem_reg_we_i,
  input  logic [1:0]      mem_wb_sel_i,
  input  logic [2:0]      mem_funct3_i,
  input  logic [XLEN-1:0] mem_alu_result_i,
  input  logic [XLEN-1:0] mem_pc_plus4_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_data_o,
  output logic            rf_we_o,
  output logic            fwd_valid_o,
  output logic            retire_o,
  output logic [63:0]     instret_o
);

  logic            valid_q,  valid_d;
  logic [4:0]      rd_q,     rd_d;
  logic            reg_we_q, reg_we_d;
  wb_sel_e         wb_sel_q, wb_sel_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] alu_q,    alu_d;
  logic [XLEN-1:0] pc4_q,    pc4_d;
  logic            first_q,  first_d;
  logic [XLEN-1:0] ldata_q,  ldata_d;

  logic [XLEN-1:0] load_word;
  logic [XLEN-1:0] load_data;
  logic            writes_rd;

  always_comb begin
    valid_d  = valid_q;
    rd_d     = rd_q;
    reg_we_d = reg_we_q;
    wb_sel_d = wb_sel_q;
    funct3_d = funct3_q;
    alu_d    = alu_q;
    pc4_d    = pc4_q;
    first_d  = first_q;
    // The memory word is only live in the first WB cycle; keep a copy for any later cycle.
    ldata_d  = first_q ? dmem_rdata_i : ldata_q;

    if (stall_i) begin
      first_d = 1'b0;
    end else begin
      rd_d     = mem_rd_i;
      wb_sel_d = wb_sel_e'(mem_wb_sel_i);
      funct3_d = mem_funct3_i;
      alu_d    = mem_alu_result_i;
      pc4_d    = mem_pc_plus4_i;
      if (flush_i) begin
        valid_d  = 1'b0;
        reg_we_d = 1'b0;
        first_d  = 1'b0;
      end else begin
        valid_d  = mem_valid_i;
        reg_we_d = mem_reg_we_i;
        first_d  = mem_valid_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      rd_q     <= '0;
      reg_we_q <= 1'b0;
      wb_sel_q <= WB_ALU;
      funct3_q <= '0;
      alu_q    <= '0;
      pc4_q    <= '0;
      first_q  <= 1'b0;
      ldata_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      rd_q     <= rd_d;
      reg_we_q <= reg_we_d;
      wb_sel_q <= wb_sel_d;
      funct3_q <= funct3_d;
      alu_q    <= alu_d;
      pc4_q    <= pc4_d;
      first_q  <= first_d;
      ldata_q  <= ldata_d;
    end
  end

  assign load_word = first_q ? dmem_rdata_i : ldata_q;

  load_align u_load_align (
    .word_i   (load_word),
    .addr_i   (alu_q[1:0]),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_comb begin
    rf_data_o = '0;
    case (wb_sel_q)
      WB_ALU:  rf_data_o = alu_q;
      WB_LOAD: rf_data_o = load_data;
      WB_PC4:  rf_data_o = pc4_q;
      default: rf_data_o = '0;
    endcase
  end

  assign writes_rd   = valid_q & reg_we_q & (rd_q != 5'd0);
  assign rf_rd_o     = rd_q;
  assign rf_we_o     = writes_rd & ~stall_i;
  assign fwd_valid_o = writes_rd;
  assign retire_o    = valid_q & ~stall_i;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (retire_o) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_o = instret_q;
`else
  assign instret_o = '0;
`endif

endmodule
